// File: rtl/nios2_debug_vjtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_debug_vjtag_pkg
//  Description : Shared types and constants for the Nios II debug vJTAG master.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios2_debug_vjtag_pkg;

    localparam int c_SR_WIDTH_DEFAULT = 38;
    localparam int c_IR_WIDTH_DEFAULT = 2;

    localparam logic [1:0] c_IR_OCIMEM    = 2'd0;
    localparam logic [1:0] c_IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] c_IR_BREAK     = 2'd2;
    localparam logic [1:0] c_IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } state_t;

    // tck only runs while a scan is actually walking the virtual TAP states
    function automatic logic scan_active(input state_t s);
        return (s != ST_IDLE) && (s != ST_RESP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_debug_vjtag_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_debug_vjtag_master_if
//  Description : Command/response handshake plus virtual-JTAG pin bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios2_debug_vjtag_master_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [SR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in,
        output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in,
        input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

endinterface
`default_nettype wire

// File: rtl/nios2_debug_vjtag_tck_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_debug_vjtag_tck_gen
//  Description : Divides clk into tck and flags the cycle before each tck edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_debug_vjtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    output logic      o_tck,
    output logic      o_rise,
    output logic      o_fall
);

    localparam int                c_HC_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [c_HC_W-1:0] c_HC_LAST = c_HC_W'(TCK_DIV - 1);

    logic [c_HC_W-1:0] r_hc;
    logic              r_tck;
    logic              w_wrap;

    assign w_wrap = i_run && (r_hc == c_HC_LAST);

    // Idle restarts the phase so every scan begins with a full low half-period
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_hc  <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_hc  <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_hc  <= r_hc + 1'b1;
        end
    end

    assign o_tck  = r_tck;
    assign o_rise = w_wrap & ~r_tck;
    assign o_fall = w_wrap &  r_tck;

endmodule
`default_nettype wire

// File: rtl/nios2_debug_vjtag_master.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_debug_vjtag_master
//  Description : Runs one UIR/CDR/SDR/UDR/RTI virtual-JTAG scan per command.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_debug_vjtag_master
    import nios2_debug_vjtag_pkg::*;
#(
    parameter int SR_WIDTH   = c_SR_WIDTH_DEFAULT,
    parameter int IR_WIDTH   = c_IR_WIDTH_DEFAULT,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    nios2_debug_vjtag_master_if.master bus
);

    localparam int                 c_BIT_W    = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
    localparam int                 c_RTI_W    = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(SR_WIDTH - 1);
    localparam logic [c_RTI_W-1:0] c_RTI_LAST = c_RTI_W'(RTI_CYCLES - 1);

    state_t              r_state;
    logic [SR_WIDTH-1:0] r_shift;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_RTI_W-1:0]  r_rti_cnt;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [SR_WIDTH-1:0] r_rsp_data;
    logic [IR_WIDTH-1:0] r_rsp_ir_out;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
    logic                r_rti;

    logic w_run;
    logic w_tck;
    logic w_rise;
    logic w_fall;

    assign w_run = scan_active(r_state);

    nios2_debug_vjtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .rst    (reset),
        .i_run  (w_run),
        .o_tck  (w_tck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Slave-visible outputs only move on fall strobes; tdo/ir_out are taken on rise strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_rti_cnt    <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_ir_out <= '0;
            r_tdi        <= 1'b0;
            r_ir_in      <= '0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_shift     <= bus.cmd_data;
                        r_ir_in     <= bus.cmd_ir;
                        r_cmd_ready <= 1'b0;
                        r_rti       <= 1'b0;
                        r_uir       <= 1'b1;
                        r_state     <= ST_UIR;
                    end
                end
                ST_UIR: begin
                    if (w_rise) begin
                        r_rsp_ir_out <= bus.vji_ir_out;
                    end
                    if (w_fall) begin
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                        r_state <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (w_fall) begin
                        r_cdr     <= 1'b0;
                        r_sdr     <= 1'b1;
                        r_tdi     <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    if (w_rise) begin
                        r_shift <= {bus.vji_tdo, r_shift[SR_WIDTH-1:1]};
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_sdr   <= 1'b0;
                            r_udr   <= 1'b1;
                            r_tdi   <= 1'b0;
                            r_state <= ST_UDR;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tdi     <= r_shift[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (w_fall) begin
                        r_udr     <= 1'b0;
                        r_rti     <= 1'b1;
                        r_rti_cnt <= '0;
                        r_state   <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (w_fall) begin
                        if (r_rti_cnt == c_RTI_LAST) begin
                            r_rsp_data  <= r_shift;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_rti_cnt <= r_rti_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_ir_out = r_rsp_ir_out;
    assign bus.vji_tck    = w_tck;
    assign bus.vji_tdi    = r_tdi;
    assign bus.vji_ir_in  = r_ir_in;
    assign bus.vji_uir    = r_uir;
    assign bus.vji_cdr    = r_cdr;
    assign bus.vji_sdr    = r_sdr;
    assign bus.vji_udr    = r_udr;
    assign bus.vji_rti    = r_rti;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_vjtag_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nios2_debug_vjtag_master
//  Description : Directed and random scans against tck-domain debug-slave models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_vjtag_master;
    import nios2_debug_vjtag_pkg::*;

    localparam int c_LAT0 = 1 + (38 + 3 + 2) * 2 * 2;
    localparam int c_LAT1 = 1 + (38 + 3 + 1) * 2 * 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nios2_debug_vjtag_master_if #(.SR_WIDTH(38), .IR_WIDTH(2)) b0 ();
    nios2_debug_vjtag_master_if #(.SR_WIDTH(38), .IR_WIDTH(2)) b1 ();

    nios2_debug_vjtag_master #(.SR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(2), .RTI_CYCLES(2))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    nios2_debug_vjtag_master #(.SR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1))
        dut1 (.clk(clk), .reset(reset), .bus(b1));

    // Debug-slave stand-ins clocked by tck, as the real sld hub would present them
    logic [37:0] s0_sr = 38'h15_AAAA_AAAA;
    logic [37:0] s0_rx = '0;
    logic [1:0]  s0_ir_out = 2'b01;
    logic [37:0] s1_sr = 38'h03_1234_5678;
    logic [37:0] s1_rx = '0;
    logic [1:0]  s1_ir_out;
    int cu0 = 0, cc0 = 0, cs0 = 0, cd0 = 0, cr0 = 0;

    assign b0.vji_tdo    = s0_sr[0];
    assign b0.vji_ir_out = s0_ir_out;
    assign b1.vji_tdo    = s1_sr[0];
    assign b1.vji_ir_out = s1_ir_out;

    always @(posedge b0.vji_tck) begin
        if (mon_en) begin
            if (b0.vji_sdr) s0_sr <= {b0.vji_tdi, s0_sr[37:1]};
            if (b0.vji_udr) s0_rx <= s0_sr;
            cu0 <= cu0 + int'(b0.vji_uir);
            cc0 <= cc0 + int'(b0.vji_cdr);
            cs0 <= cs0 + int'(b0.vji_sdr);
            cd0 <= cd0 + int'(b0.vji_udr);
            cr0 <= cr0 + int'(b0.vji_rti);
        end
    end

    always @(posedge b1.vji_tck) begin
        if (mon_en) begin
            if (b1.vji_sdr) s1_sr <= {b1.vji_tdi, s1_sr[37:1]};
            if (b1.vji_udr) s1_rx <= s1_sr;
        end
    end

    int   viol_hot = 0;
    int   viol_tdi = 0;
    logic p_tdi = 1'b0, p_tck = 1'b0, p_rst = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones({b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti}) != 1 ||
                $countones({b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti}) != 1)
                viol_hot <= viol_hot + 1;
            if (!p_rst && (b0.vji_tdi != p_tdi) && !(p_tck && !b0.vji_tck))
                viol_tdi <= viol_tdi + 1;
        end
        p_tdi <= b0.vji_tdi;
        p_tck <= b0.vji_tck;
        p_rst <= reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int w, input logic v, input logic [1:0] ir, input logic [37:0] d);
        if (w == 0) begin b0.cmd_valid = v; b0.cmd_ir = ir; b0.cmd_data = d; end
        else        begin b1.cmd_valid = v; b1.cmd_ir = ir; b1.cmd_data = d; end
    endtask

    task automatic set_rdy(input int w, input logic r);
        if (w == 0) b0.rsp_ready = r;
        else        b1.rsp_ready = r;
    endtask

    // {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti}
    function automatic logic [8:0] flags(input int w);
        if (w == 0)
            return {b0.cmd_ready, b0.rsp_valid, b0.vji_tck, b0.vji_tdi,
                    b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti};
        return {b1.cmd_ready, b1.rsp_valid, b1.vji_tck, b1.vji_tdi,
                b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti};
    endfunction

    function automatic logic [37:0] rdata(input int w);
        return (w == 0) ? b0.rsp_data : b1.rsp_data;
    endfunction

    function automatic logic [1:0] rir(input int w);
        return (w == 0) ? b0.rsp_ir_out : b1.rsp_ir_out;
    endfunction

    function automatic logic [1:0] irin(input int w);
        return (w == 0) ? b0.vji_ir_in : b1.vji_ir_in;
    endfunction

    function automatic logic [37:0] rx(input int w);
        return (w == 0) ? s0_rx : s1_rx;
    endfunction

    // Called in the first cycle after acceptance; measures cycles to rsp_valid
    task automatic wait_rsp(input int w, input int lat, input string tag);
        int t = 1;
        while (!flags(w)[7] && t < lat + 50) begin
            tick();
            t++;
        end
        check({tag, ".latency"}, 64'(t), 64'(lat));
    endtask

    task automatic handshake(input int w, input string tag);
        set_rdy(w, 1'b1);
        tick();
        set_rdy(w, 1'b0);
        check({tag, ".after_take"}, 64'(flags(w)[8:7]), 64'(2'b10));
    endtask

    task automatic do_scan(input int w, input logic [1:0] ir, input logic [37:0] d,
                           input logic [37:0] exp_rsp, input logic [1:0] exp_ir,
                           input int lat, input int stall, input string tag);
        set_cmd(w, 1'b1, ir, d);
        check({tag, ".ready"}, 64'(flags(w)[8]), 64'(1));
        tick();
        set_cmd(w, 1'b0, ir, d);
        check({tag, ".ir_in"}, 64'(irin(w)), 64'(ir));
        wait_rsp(w, lat, tag);
        check({tag, ".rsp_data"}, 64'(rdata(w)), 64'(exp_rsp));
        check({tag, ".rsp_ir_out"}, 64'(rir(w)), 64'(exp_ir));
        check({tag, ".slave_rx"}, 64'(rx(w)), 64'(d));
        repeat (stall) tick();
        if (stall > 0) check({tag, ".held"}, {25'd0, flags(w)[7], rdata(w)}, {25'd0, 1'b1, exp_rsp});
        handshake(w, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] mem0, mem1, x, y, z, d;
        logic [63:0] r64;
        logic [1:0]  ir, iro;
        int su, sc, ss, sd, sr, stall;

        mem0 = 38'h15_AAAA_AAAA;
        mem1 = 38'h03_1234_5678;
        s1_ir_out = 2'b10;
        set_cmd(0, 1'b0, 2'b00, '0);
        set_cmd(1, 1'b0, 2'b00, '0);
        set_rdy(0, 1'b0);
        set_rdy(1, 1'b0);
        repeat (3) tick();
        check("reset.flags0", 64'(flags(0)), 64'(9'b1_0_0_0_0000_1));
        check("reset.flags1", 64'(flags(1)), 64'(9'b1_0_0_0_0000_1));
        check("reset.rsp0", {22'd0, rdata(0), rir(0), irin(0)}, 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single scan with flag audit
        su = cu0; sc = cc0; ss = cs0; sd = cd0; sr = cr0;
        do_scan(0, c_IR_BREAK, 38'h2A_5555_5555, mem0, 2'b01, c_LAT0, 0, "scan1");
        mem0 = 38'h2A_5555_5555;
        check("audit.uir", 64'(cu0 - su), 64'd1);
        check("audit.cdr", 64'(cc0 - sc), 64'd1);
        check("audit.sdr", 64'(cs0 - ss), 64'd38);
        check("audit.udr", 64'(cd0 - sd), 64'd1);
        check("audit.rti", 64'(cr0 - sr), 64'd2);

        // Backpressure with cmd_valid held high throughout
        x = 38'h1C_0F0F_3C3C;
        y = 38'h07_DEAD_BEEF;
        set_cmd(0, 1'b1, c_IR_TRACEMEM, x);
        tick();
        b0.cmd_data = ~x;
        wait_rsp(0, c_LAT0, "bp1");
        check("bp1.rsp_data", 64'(rdata(0)), 64'(mem0));
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp.hold_flags", 64'(flags(0)[8:7]), 64'(2'b01));
            check("bp.hold_data", 64'(rdata(0)), 64'(mem0));
        end
        mem0 = x;
        b0.cmd_ir = c_IR_TRACECTRL;
        b0.cmd_data = y;
        handshake(0, "bp1");
        check("bp.ir_held", 64'(irin(0)), 64'(c_IR_TRACEMEM));
        check("bp.slave_rx", 64'(s0_rx), 64'(x));
        tick();
        b0.cmd_valid = 1'b0;
        check("bp2.accept", 64'({flags(0)[8], flags(0)[4]}), 64'(2'b01));
        check("bp2.ir_in", 64'(irin(0)), 64'(c_IR_TRACECTRL));
        wait_rsp(0, c_LAT0, "bp2");
        check("bp2.rsp_data", 64'(rdata(0)), 64'(mem0));
        handshake(0, "bp2");
        mem0 = y;

        // Reset during the 10th SDR period (tck high, 10 slave shifts done)
        z = 38'h2B_3C4D_5E6F;
        sd = cd0;
        set_cmd(0, 1'b1, c_IR_OCIMEM, z);
        tick();
        set_cmd(0, 1'b0, c_IR_OCIMEM, z);
        repeat (46) tick();
        check("rst.pre_sdr_tck", 64'({b0.vji_sdr, b0.vji_tck}), 64'(2'b11));
        reset = 1'b1;
        tick();
        check("rst.flags", 64'(flags(0)), 64'(9'b1_0_0_0_0000_1));
        check("rst.ir_in", 64'(irin(0)), 64'd0);
        reset = 1'b0;
        tick();
        mem0 = ((mem0 >> 10) | (z << 28)) & 38'h3F_FFFF_FFFF;
        do_scan(0, c_IR_OCIMEM, 38'h0, mem0, 2'b01, c_LAT0, 3, "post_rst");
        check("rst.no_udr", 64'(cd0 - sd), 64'd1);
        mem0 = 38'h0;

        // Fast variant: back-to-back commands
        for (int i = 0; i < 4; i++) begin
            r64 = {$urandom(), $urandom()};
            d = r64[37:0];
            ir = 2'(i);
            do_scan(1, ir, d, mem1, s1_ir_out, c_LAT1, 0, "b2b");
            mem1 = d;
        end

        // Random scans with random response stalls
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom(), $urandom()};
            d = r64[37:0];
            ir = 2'($urandom_range(0, 3));
            iro = 2'($urandom_range(0, 3));
            s1_ir_out = iro;
            stall = int'($urandom_range(0, 3));
            do_scan(1, ir, d, mem1, iro, c_LAT1, stall, "rand");
            mem1 = d;
        end

        tick();
        check("audit.onehot", 64'(viol_hot), 64'd0);
        check("audit.tdi_edges", 64'(viol_tdi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
